// File: rtl/i2c_master_ctrl.sv
// Single-register I2C master: one command becomes START, {dev,0}, reg, then wdata or a read of one byte, then STOP.
// Latency: write 116*QUARTER+1 cycles, read 156*QUARTER+1 cycles (160*QUARTER+1 when reads use STOP+START).
// Backpressure: iStart is honoured only while oBusy=0; commands offered while busy or during DONE are dropped.
// Build option I2C_MASTER_REPSTART_EN: defined = reads use a repeated START; undefined = reads use STOP then START.
module i2c_master_ctrl #(
  parameter int QUARTER = 5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       iStart,
  input  logic       iRW,
  input  logic [6:0] iDevAddr,
  input  logic [7:0] iRegAddr,
  input  logic [7:0] iWData,
  output logic       oBusy,
  output logic       oDone,
  output logic       oAckErr,
  output logic [7:0] oRData,
  output logic       SCL,
  input  logic       iSDA,
  output logic       oSDA
);

  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);

  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_ACK, STOP, DONE
  } stateT;

  stateT         state;
  logic [QW-1:0] qCnt;      // CLK cycles within the current quarter
  logic [1:0]    phase;     // quarter within the bit slot (Q0..Q3)
  logic [2:0]    bitCnt;    // bits left in the current byte, 7 -> 0
  logic [1:0]    byteIdx;   // 0 = {dev,0}, 1 = reg, 2 = wdata or {dev,1}
  logic          rwLat;
  logic [6:0]    devLat;
  logic [7:0]    regLat;
  logic [7:0]    wdLat;
  logic [7:0]    txShift;
  logic [7:0]    rxShift;
  logic          ackBit;    // SDA captured at the end of Q2 of the current slot
  logic          nackSeen;
  logic          again;     // STOP is followed by a fresh START for the read address

  // Line levels {SCL, oSDA} for a quarter of a given state; d is the data bit for TX_BYTE.
  // SCL is high in Q2/Q3 of every data/ack slot; START/RESTART/STOP have their own edge patterns.
  function automatic logic [1:0] busLines(input stateT st, input logic [1:0] ph, input logic d);
    logic hi;
    hi = ph[1];
    case (st)
      START:   busLines = (ph == 2'd0) ? 2'b11 : (ph == 2'd1) ? 2'b10 : 2'b00;
      RESTART: busLines = (ph == 2'd0) ? 2'b01 : (ph == 2'd1) ? 2'b11 :
                          (ph == 2'd2) ? 2'b10 : 2'b00;
      STOP:    busLines = (ph == 2'd0) ? 2'b00 : (ph == 2'd1) ? 2'b10 : 2'b11;
      TX_BYTE: busLines = {hi, d};
      RX_ACK, RX_BYTE, TX_ACK: busLines = {hi, 1'b1};
      default: busLines = 2'b11;
    endcase
  endfunction

  // Command latch, quarter/bit sequencing and registered bus outputs; line levels for a quarter
  // are loaded on the edge that starts it, so SCL/oSDA never lag the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      qCnt     <= '0;
      phase    <= '0;
      bitCnt   <= '0;
      byteIdx  <= '0;
      rwLat    <= 1'b0;
      devLat   <= '0;
      regLat   <= '0;
      wdLat    <= '0;
      txShift  <= '0;
      rxShift  <= '0;
      ackBit   <= 1'b1;
      nackSeen <= 1'b0;
      again    <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oAckErr  <= 1'b0;
      oRData   <= '0;
      SCL      <= 1'b1;
      oSDA     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            rwLat    <= iRW;
            devLat   <= iDevAddr;
            regLat   <= iRegAddr;
            wdLat    <= iWData;
            state    <= START;
            qCnt     <= '0;
            phase    <= 2'd0;
            byteIdx  <= 2'd0;
            nackSeen <= 1'b0;
            again    <= 1'b0;
            oBusy    <= 1'b1;
            oAckErr  <= 1'b0;
            {SCL, oSDA} <= busLines(START, 2'd0, 1'b1);
          end
        end

        DONE: begin
          state <= IDLE;
          oDone <= 1'b0;
          oBusy <= 1'b0;
        end

        default: begin
          if (qCnt != QLAST) begin
            qCnt <= qCnt + 1'b1;
          end else begin
            qCnt <= '0;
            // Last CLK of Q2: SCL has been high for a full quarter, the line is settled.
            if (phase == 2'd2) begin
              ackBit <= iSDA;
              if (state == RX_BYTE) rxShift <= {rxShift[6:0], iSDA};
            end
            if (phase != 2'd3) begin
              phase <= phase + 2'd1;
              {SCL, oSDA} <= busLines(state, phase + 2'd1, txShift[7]);
            end else begin
              phase <= 2'd0;
              case (state)
                START: begin
                  state   <= TX_BYTE;
                  bitCnt  <= 3'd7;
                  txShift <= {devLat, byteIdx[1]};
                  {SCL, oSDA} <= busLines(TX_BYTE, 2'd0, devLat[6]);
                end

                TX_BYTE: begin
                  if (bitCnt == 3'd0) begin
                    state <= RX_ACK;
                    {SCL, oSDA} <= busLines(RX_ACK, 2'd0, 1'b1);
                  end else begin
                    bitCnt  <= bitCnt - 3'd1;
                    txShift <= {txShift[6:0], 1'b0};
                    {SCL, oSDA} <= busLines(TX_BYTE, 2'd0, txShift[6]);
                  end
                end

                RX_ACK: begin
                  if (ackBit) begin
                    nackSeen <= 1'b1;
                    state    <= STOP;
                    {SCL, oSDA} <= busLines(STOP, 2'd0, 1'b1);
                  end else begin
                    case (byteIdx)
                      2'd0: begin
                        byteIdx <= 2'd1;
                        state   <= TX_BYTE;
                        bitCnt  <= 3'd7;
                        txShift <= regLat;
                        {SCL, oSDA} <= busLines(TX_BYTE, 2'd0, regLat[7]);
                      end
                      2'd1: begin
                        if (rwLat) begin
`ifdef I2C_MASTER_REPSTART_EN
                          state <= RESTART;
                          {SCL, oSDA} <= busLines(RESTART, 2'd0, 1'b1);
`else
                          state <= STOP;
                          again <= 1'b1;
                          {SCL, oSDA} <= busLines(STOP, 2'd0, 1'b1);
`endif
                        end else begin
                          byteIdx <= 2'd2;
                          state   <= TX_BYTE;
                          bitCnt  <= 3'd7;
                          txShift <= wdLat;
                          {SCL, oSDA} <= busLines(TX_BYTE, 2'd0, wdLat[7]);
                        end
                      end
                      2'd2: begin
                        if (rwLat) begin
                          state  <= RX_BYTE;
                          bitCnt <= 3'd7;
                          {SCL, oSDA} <= busLines(RX_BYTE, 2'd0, 1'b1);
                        end else begin
                          state <= STOP;
                          {SCL, oSDA} <= busLines(STOP, 2'd0, 1'b1);
                        end
                      end
                      default: begin
                        state <= STOP;
                        {SCL, oSDA} <= busLines(STOP, 2'd0, 1'b1);
                      end
                    endcase
                  end
                end

                RESTART: begin
                  byteIdx <= 2'd2;
                  state   <= TX_BYTE;
                  bitCnt  <= 3'd7;
                  txShift <= {devLat, 1'b1};
                  {SCL, oSDA} <= busLines(TX_BYTE, 2'd0, devLat[6]);
                end

                RX_BYTE: begin
                  if (bitCnt == 3'd0) begin
                    state <= TX_ACK;
                    {SCL, oSDA} <= busLines(TX_ACK, 2'd0, 1'b1);
                  end else begin
                    bitCnt <= bitCnt - 3'd1;
                    {SCL, oSDA} <= busLines(RX_BYTE, 2'd0, 1'b1);
                  end
                end

                TX_ACK: begin
                  state <= STOP;
                  {SCL, oSDA} <= busLines(STOP, 2'd0, 1'b1);
                end

                STOP: begin
                  if (again) begin
                    again   <= 1'b0;
                    byteIdx <= 2'd2;
                    state   <= START;
                    {SCL, oSDA} <= busLines(START, 2'd0, 1'b1);
                  end else begin
                    state   <= DONE;
                    oDone   <= 1'b1;
                    oAckErr <= nackSeen;
                    if (rwLat && !nackSeen) oRData <= rxShift;
                    {SCL, oSDA} <= 2'b11;
                  end
                end

                default: begin
                  state <= IDLE;
                  {SCL, oSDA} <= 2'b11;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a clock-sampled I2C responder on the bus.
// Latency is reported as the cycle index of the oDone pulse, cycle T+1 being the first after acceptance edge T.
// Responder ACKs every master byte except the frame selected by nackAt and returns rdByte on reads.
module tb_i2c_master_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       iStart;
  logic       iRW;
  logic [6:0] iDevAddr;
  logic [7:0] iRegAddr;
  logic [7:0] iWData;
  logic       oBusy;
  logic       oDone;
  logic       oAckErr;
  logic [7:0] oRData;
  logic       SCL;
  logic       oSDA;
  logic       sdaLine;

  i2c_master_ctrl #(.QUARTER(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .iStart(iStart), .iRW(iRW),
    .iDevAddr(iDevAddr), .iRegAddr(iRegAddr), .iWData(iWData),
    .oBusy(oBusy), .oDone(oDone), .oAckErr(oAckErr), .oRData(oRData),
    .SCL(SCL), .iSDA(sdaLine), .oSDA(oSDA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Responder model and bus log (START = 0x100, STOP = 0x101, bytes 0x000-0x0FF)
  logic       sdaS = 1'b1;
  logic       sclP = 1'b1;
  logic       sdaP = 1'b1;
  logic [3:0] bitNum = 4'd0;
  logic [3:0] frameIdx = 4'd0;
  logic       rdMode = 1'b0;
  logic [7:0] sh = 8'd0;
  logic       masterAck = 1'b0;
  logic [3:0] nackAt;
  logic [7:0] rdByte;
  logic [8:0] busLog[$];
  logic [8:0] expQ[$];

  assign sdaLine = oSDA & sdaS;

  always @(negedge CLK) begin
    sclP <= SCL;
    sdaP <= oSDA;
    if (!sclP && SCL) begin
      if (bitNum < 4'd8) begin
        sh <= {sh[6:0], sdaLine};
        if (bitNum == 4'd7) begin
          busLog.push_back({1'b0, sh[6:0], sdaLine});
          if (frameIdx == 4'd0) rdMode <= sdaLine;
        end
        bitNum <= bitNum + 4'd1;
      end else begin
        if (rdMode && frameIdx == 4'd1) masterAck <= sdaLine;
        bitNum   <= 4'd0;
        frameIdx <= frameIdx + 4'd1;
      end
    end
    if (sclP && !SCL) begin
      if (bitNum == 4'd8)
        sdaS <= (rdMode && frameIdx == 4'd1) ? 1'b1 : (frameIdx == nackAt);
      else
        sdaS <= (rdMode && frameIdx == 4'd1) ? rdByte[3'd7 - bitNum[2:0]] : 1'b1;
    end
    if (sclP && SCL && sdaP && !oSDA) begin
      busLog.push_back(9'h100);
      bitNum <= 4'd0; frameIdx <= 4'd0; rdMode <= 1'b0; sdaS <= 1'b1;
    end
    if (sclP && SCL && !sdaP && oSDA) begin
      busLog.push_back(9'h101);
      bitNum <= 4'd0; frameIdx <= 4'd0; rdMode <= 1'b0; sdaS <= 1'b1;
    end
  end

  int checks = 0;
  int passed = 0;
  int fails = 0;
  int tAcc = 0;
  int logBase = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkLog(input string tag);
    logic [31:0] obsv;
    check({tag, "_len"}, busLog.size() - logBase, expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      obsv = (logBase + i < busLog.size()) ? {23'd0, busLog[logBase + i]} : 32'hDEAD;
      check($sformatf("%s_ev%0d", tag, i), obsv, {23'd0, expQ[i]});
    end
  endtask

  task automatic issue(input logic rw, input logic [6:0] d, input logic [7:0] r, input logic [7:0] w);
    @(negedge CLK);
    logBase  = busLog.size();
    iRW      = rw;
    iDevAddr = d;
    iRegAddr = r;
    iWData   = w;
    iStart   = 1'b1;
    @(negedge CLK);
    tAcc   = cyc;
    iStart = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 3000 && lat < 0) begin
      @(negedge CLK);
      n++;
      if (oDone === 1'b1) lat = cyc - tAcc + 1;
    end
  endtask

  initial begin
    int lat;
    int n;
    int sizeAtDone;
    logic sawBusy;

    RST_N = 1'b0; iStart = 1'b0; iRW = 1'b0; iDevAddr = '0; iRegAddr = '0; iWData = '0;
    nackAt = 4'hF; rdByte = 8'hA5;
    repeat (3) @(negedge CLK);
    check("rst_scl", SCL, 1);
    check("rst_sda", oSDA, 1);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_ackerr", oAckErr, 0);
    check("rst_rdata", oRData, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Plain write
    issue(1'b0, 7'h2A, 8'h10, 8'hC3);
    check("wr_busy", oBusy, 1);
    waitDone(lat);
    check("wr_lat", lat, 581);
    check("wr_ackerr", oAckErr, 0);
    expQ = '{9'h100, 9'h054, 9'h010, 9'h0C3, 9'h101};
    checkLog("wr");
    @(negedge CLK);
    check("wr_done_one_cycle", oDone, 0);
    check("wr_busy_clear", oBusy, 0);
    check("wr_rdata_kept", oRData, 0);

    // Read
    issue(1'b1, 7'h2A, 8'h05, 8'h00);
    waitDone(lat);
`ifdef I2C_MASTER_REPSTART_EN
    check("rd_lat", lat, 781);
    expQ = '{9'h100, 9'h054, 9'h005, 9'h100, 9'h055, 9'h0A5, 9'h101};
`else
    check("rd_lat", lat, 801);
    expQ = '{9'h100, 9'h054, 9'h005, 9'h101, 9'h100, 9'h055, 9'h0A5, 9'h101};
`endif
    checkLog("rd");
    check("rd_data", oRData, 8'hA5);
    check("rd_ackerr", oAckErr, 0);
    check("rd_master_nack", masterAck, 1);

    // Address NACK
    nackAt = 4'd0;
    issue(1'b0, 7'h2A, 8'h33, 8'h77);
    waitDone(lat);
    check("nack_addr_lat", lat, 221);
    check("nack_addr_err", oAckErr, 1);
    check("nack_addr_rdata", oRData, 8'hA5);
    expQ = '{9'h100, 9'h054, 9'h101};
    checkLog("nack_addr");
    @(negedge CLK);
    check("nack_err_holds", oAckErr, 1);

    // NACK on the data byte of a write
    nackAt = 4'd2;
    issue(1'b0, 7'h2A, 8'h10, 8'hC3);
    waitDone(lat);
    check("nack_data_lat", lat, 581);
    check("nack_data_err", oAckErr, 1);
    expQ = '{9'h100, 9'h054, 9'h010, 9'h0C3, 9'h101};
    checkLog("nack_data");

    // Write with iStart pulsed while busy and during DONE
    nackAt = 4'hF;
    issue(1'b0, 7'h50, 8'h01, 8'h5A);
    check("err_cleared_on_accept", oAckErr, 0);
    repeat (150) @(negedge CLK);
    iRW = 1'b1; iDevAddr = 7'h11; iRegAddr = 8'hEE; iWData = 8'h00; iStart = 1'b1;
    @(negedge CLK);
    iStart = 1'b0;
    waitDone(lat);
    iRW = 1'b0; iDevAddr = 7'h7F; iRegAddr = 8'h99; iWData = 8'h66; iStart = 1'b1;
    @(negedge CLK);
    iStart = 1'b0;
    check("busy_ign_lat", lat, 581);
    check("busy_ign_err", oAckErr, 0);
    expQ = '{9'h100, 9'h0A0, 9'h001, 9'h05A, 9'h101};
    checkLog("busy_ign");
    sizeAtDone = busLog.size();
    sawBusy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (oBusy === 1'b1) sawBusy = 1'b1;
    end
    check("no_queued_cmd_busy", sawBusy, 0);
    check("no_queued_cmd_bus", busLog.size(), sizeAtDone);

    // Reset during the register byte, then a clean write
    issue(1'b0, 7'h2A, 8'h10, 8'hC3);
    n = 0;
    while (busLog.size() < logBase + 2 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("mid_reached_reg_byte", busLog.size() >= logBase + 2, 1);
    repeat (40) @(negedge CLK);
    n = 0;
    while (SCL !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("mid_busy_before_rst", oBusy, 1);
    #1 RST_N = 1'b0;
    #1;
    check("mid_rst_scl", SCL, 1);
    check("mid_rst_sda", oSDA, 1);
    check("mid_rst_busy", oBusy, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    issue(1'b0, 7'h3C, 8'h7E, 8'h81);
    waitDone(lat);
    check("post_rst_lat", lat, 581);
    check("post_rst_err", oAckErr, 0);
    expQ = '{9'h100, 9'h078, 9'h07E, 9'h081, 9'h101};
    checkLog("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Single-register I2C master (initiator) for the USB project I2C bus. It accepts a one-shot command (device address, register address, read/write, write data) from local logic. It then generates the complete I2C transaction on SCL/SDA: START, address byte, register byte, data byte or repeated-START read, and STOP. It is the controlling end for the register-mapped I2C responder already on the bus, and reports read data and acknowledge errors back to the requester.

## Interface
Parameters:
- QUARTER, default 5: CLK cycles per quarter SCL bit period. Valid range is ≥2. The SCL period is 4*QUARTER CLK cycles.

Ports:
- CLK  in  1  system clock. All logic is on its rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- iStart  in  1  command strobe. Sampled only while oBusy=0.
- iRW  in  1  command type: 1 = read, 0 = write.
- iDevAddr  in  7  7-bit target device address.
- iRegAddr  in  8  target register address.
- iWData  in  8  byte to write. Ignored for reads.
- oBusy  out  1  high from the cycle after iStart is accepted until oDone.
- oDone  out  1  one-cycle pulse when the transaction ends.
- oAckErr  out  1  valid with oDone: 1 = a responder NACK caused an abort. Holds until the next accepted command.
- oRData  out  8  read byte. Updated at oDone for a successful read only.
- SCL  out  1  I2C clock. 1 = released/high.
- iSDA  in  1  sampled SDA line.
- oSDA  out  1  SDA drive: 0 = pull low, 1 = release.

## Operation
- On iStart with oBusy=0, latch iRW, iDevAddr, iRegAddr and iWData. Later input changes have no effect.
- Bit timing: each bit slot is four quarters, Q0..Q3.
  - Q0: SCL=0; oSDA is updated at the start of Q0.
  - Q1: SCL=0.
  - Q2–Q3: SCL=1.
  - iSDA is sampled on the last CLK cycle of Q2.
- States and transitions:
  - IDLE → START on an accepted command.
  - START (4 quarters): SDA=1/SCL=1, then SDA=0 with SCL=1, then SCL=0. Next state is TX_BYTE.
  - TX_BYTE: 8 bits, MSB first. Next state is RX_ACK.
  - RX_ACK: oSDA=1; sample iSDA. If iSDA=1 (NACK), set an error flag and go to STOP. Otherwise go to the next phase.
  - RESTART (read only, 4 quarters): SDA=1 with SCL low, SCL high, SDA=0, SCL low. Next state is TX_BYTE with {dev,1}.
  - RX_BYTE: oSDA=1; shift in 8 bits MSB first. Next state is TX_ACK.
  - TX_ACK: oSDA=1 (NACK, final byte). Next state is STOP.
  - STOP (4 quarters): SDA=0/SCL=0, SCL=1, then SDA=1. Next state is DONE.
  - DONE (1 cycle): oDone=1. Next state is IDLE.
- Byte sequences:
  - Write: {dev,0}, reg, wdata.
  - Read: {dev,0}, reg, RESTART, {dev,1}, then read byte.
- Internal counters:
  - Quarter counter: ceil(log2(QUARTER)) bits, wraps QUARTER-1 → 0.
  - Bit counter: 3 bits, counts 7 → 0.
  - Byte index: 2 bits.

## Timing
- Reset values: SCL=1, oSDA=1, oBusy=0, oDone=0, oAckErr=0, oRData=0. State is IDLE.
- Reset asserted mid-transaction releases both lines immediately. No STOP is generated.
- Acceptance is at edge T; START Q0 begins at T+1.
- Latency from acceptance to oDone:
  - Write: oDone high in cycle T+116*QUARTER+1. That is 4 + 27 bits×4 + 4 quarters.
  - Read: oDone high in cycle T+156*QUARTER+1.
  - NACK on byte k (k = 1..3): oDone follows STOP, which immediately follows that byte's ACK slot.
- iStart while oBusy=1 or during the DONE cycle is ignored and not queued.
- iStart in the cycle after DONE is accepted. Back-to-back commands therefore have a one-cycle IDLE gap.
- oSDA only changes while SCL=0, except during START, RESTART and STOP edges.

## Configuration
- I2C_MASTER_REPSTART_EN:
  - Defined: reads use RESTART between the register byte and {dev,1}.
  - Undefined: reads issue a full STOP, then a new START (8 quarters), before {dev,1`}. Read latency becomes 160*QUARTER+1.
  - Writes are identical in both builds.

## Test plan
- Write, QUARTER=5: dev=0x2A, reg=0x10, wdata=0xC3, responder ACKs all bytes. Bus bytes must be 0x54, 0x10, 0xC3. oDone at T+581; oAckErr=0.
- Read: dev=0x2A, reg=0x05, responder returns 0xA5. Bus bytes must be 0x54, 0x05, RESTART, 0x55; the master drives NACK. oRData=0xA5 at oDone, T+781.
- Address NACK: responder leaves SDA high after the first byte. STOP follows immediately; oDone pulses with oAckErr=1; oRData is unchanged.
- iStart pulsed while busy with different fields: the bus traffic and latency of the first command are unchanged, and no second transaction occurs.
- RST_N low during the register byte: SCL=1, oSDA=1 and oBusy=0 asynchronously. A new write after release completes normally.
- Undefined I2C_MASTER_REPSTART_EN, same read: STOP/START appears in place of RESTART; oDone at T+801.
